// File: rtl/gesture_decision_unit.sv
// Gesture decision stage: serial best/runner-up scan of a class score vector,
// threshold + margin test, same-class persistence filter and optional cooldown.
module gesture_decision_unit #(
  parameter int NUM_CLASSES       = 4,
  parameter int ACC_BITS          = 24,
  parameter int MIN_SCORE_THRESH  = 30,
  parameter int MIN_MARGIN        = 8,
  parameter int PERSISTENCE_COUNT = 2,
  parameter int CONF_SHIFT        = 3,
  parameter int COOLDOWN_CYCLES   = 0,
  localparam int CLASS_BITS  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int STREAK_BITS = ($clog2(PERSISTENCE_COUNT + 1) > 0) ? $clog2(PERSISTENCE_COUNT + 1) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            scores_valid,
  input  logic [NUM_CLASSES*ACC_BITS-1:0] scores_flat,
  output logic                            scores_ready,
  output logic [CLASS_BITS-1:0]           gesture,
  output logic                            gesture_valid,
  output logic [3:0]                      gesture_confidence,
  output logic                            decision_done,
  output logic                            decision_pass,
  output logic [2:0]                      debug_state,
  output logic [STREAK_BITS-1:0]          debug_streak
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SCAN     = 3'd1;
  localparam logic [2:0] S_DECIDE   = 3'd2;
  localparam logic [2:0] S_COOLDOWN = 3'd3;

  localparam int CD_BITS = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [CD_BITS-1:0]         CD_LOAD    = CD_BITS'(COOLDOWN_CYCLES - 1);
  localparam logic [CLASS_BITS-1:0]      LAST_IDX   = CLASS_BITS'(NUM_CLASSES - 1);
  localparam logic [STREAK_BITS-1:0]     PERSIST    = STREAK_BITS'(PERSISTENCE_COUNT);
  localparam logic signed [ACC_BITS-1:0] MOST_NEG   = {1'b1, {(ACC_BITS-1){1'b0}}};
  localparam logic signed [ACC_BITS:0]   THRESH_EXT = (ACC_BITS+1)'(MIN_SCORE_THRESH);
  localparam logic signed [ACC_BITS:0]   MARGIN_EXT = (ACC_BITS+1)'(MIN_MARGIN);
  localparam logic signed [ACC_BITS:0]   CONF_MAX   = (ACC_BITS+1)'(15);

  logic [2:0]                      state_q, state_d;
  logic [NUM_CLASSES*ACC_BITS-1:0] scores_q, scores_d;
  logic [CLASS_BITS-1:0]           idx_q, idx_d;
  logic signed [ACC_BITS-1:0]      best_q, best_d;
  logic signed [ACC_BITS-1:0]      second_q, second_d;
  logic [CLASS_BITS-1:0]           best_idx_q, best_idx_d;
  logic [STREAK_BITS-1:0]          streak_q, streak_d;
  logic [CLASS_BITS-1:0]           cand_q, cand_d;
  logic                            cand_valid_q, cand_valid_d;
  logic [CD_BITS-1:0]              cd_cnt_q, cd_cnt_d;
  logic [CLASS_BITS-1:0]           gesture_q, gesture_d;
  logic                            gesture_valid_q, gesture_valid_d;
  logic [3:0]                      conf_q, conf_d;
  logic                            done_q, done_d;
  logic                            pass_q, pass_d;

  logic signed [ACC_BITS-1:0] cur_score;
  logic signed [ACC_BITS:0]   best_ext, second_ext, margin, conf_shifted;
  logic                       pass;
  logic [3:0]                 conf_sat;
  logic [STREAK_BITS-1:0]     streak_next;

  assign cur_score    = scores_q[int'(idx_q)*ACC_BITS +: ACC_BITS];
  assign best_ext     = {best_q[ACC_BITS-1], best_q};
  assign second_ext   = {second_q[ACC_BITS-1], second_q};
  // One extra bit keeps best - second exact even against the most-negative seed.
  assign margin       = best_ext - second_ext;
  assign pass         = (best_ext >= THRESH_EXT) && (margin >= MARGIN_EXT);
  assign conf_shifted = margin >>> CONF_SHIFT;
  assign conf_sat     = (conf_shifted > CONF_MAX) ? 4'd15 : conf_shifted[3:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d         = state_q;
    scores_d        = scores_q;
    idx_d           = idx_q;
    best_d          = best_q;
    second_d        = second_q;
    best_idx_d      = best_idx_q;
    streak_d        = streak_q;
    cand_d          = cand_q;
    cand_valid_d    = cand_valid_q;
    cd_cnt_d        = cd_cnt_q;
    gesture_d       = gesture_q;
    gesture_valid_d = 1'b0;
    conf_d          = conf_q;
    done_d          = 1'b0;
    pass_d          = pass_q;
    streak_next     = STREAK_BITS'(1);

    case (state_q)
      S_IDLE: begin
        if (scores_valid) begin
          scores_d   = scores_flat;
          idx_d      = '0;
          best_d     = MOST_NEG;
          second_d   = MOST_NEG;
          best_idx_d = '0;
          state_d    = S_SCAN;
        end
      end
      S_SCAN: begin
        // Strict compares keep the lower index on ties; the tied value still enters second.
        if (idx_q == '0) begin
          best_d     = cur_score;
          best_idx_d = '0;
        end else if (cur_score > best_q) begin
          second_d   = best_q;
          best_d     = cur_score;
          best_idx_d = idx_q;
        end else if (cur_score > second_q) begin
          second_d   = cur_score;
        end
        if (idx_q == LAST_IDX) state_d = S_DECIDE;
        else                   idx_d   = idx_q + CLASS_BITS'(1);
      end
      S_DECIDE: begin
        done_d  = 1'b1;
        pass_d  = pass;
        state_d = S_IDLE;
        if (!pass) begin
          streak_d     = '0;
          cand_valid_d = 1'b0;
        end else begin
          if (cand_valid_q && (cand_q == best_idx_q)) streak_next = streak_q + STREAK_BITS'(1);
          if (streak_next == PERSIST) begin
            gesture_d       = best_idx_q;
            conf_d          = conf_sat;
            gesture_valid_d = 1'b1;
            streak_d        = '0;
            cand_valid_d    = 1'b0;
            if (COOLDOWN_CYCLES > 0) begin
              state_d  = S_COOLDOWN;
              cd_cnt_d = CD_LOAD;
            end
          end else begin
            streak_d     = streak_next;
            cand_d       = best_idx_q;
            cand_valid_d = 1'b1;
          end
        end
      end
      S_COOLDOWN: begin
        if (cd_cnt_q == '0) state_d  = S_IDLE;
        else                cd_cnt_d = cd_cnt_q - CD_BITS'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the latched score vector is pure data qualified by state, so it carries no reset.
  always_ff @(posedge clk) begin
    scores_q <= scores_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      best_q          <= '0;
      second_q        <= '0;
      best_idx_q      <= '0;
      streak_q        <= '0;
      cand_q          <= '0;
      cand_valid_q    <= 1'b0;
      cd_cnt_q        <= '0;
      gesture_q       <= '0;
      gesture_valid_q <= 1'b0;
      conf_q          <= '0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      best_q          <= best_d;
      second_q        <= second_d;
      best_idx_q      <= best_idx_d;
      streak_q        <= streak_d;
      cand_q          <= cand_d;
      cand_valid_q    <= cand_valid_d;
      cd_cnt_q        <= cd_cnt_d;
      gesture_q       <= gesture_d;
      gesture_valid_q <= gesture_valid_d;
      conf_q          <= conf_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
    end
  end

  // Ready is masked while rst is high so every output reads 0 during reset.
  assign scores_ready       = (state_q == S_IDLE) && !rst;
  assign gesture            = gesture_q;
  assign gesture_valid      = gesture_valid_q;
  assign gesture_confidence = conf_q;
  assign decision_done      = done_q;
  assign decision_pass      = pass_q;
  assign debug_state        = state_q;
  assign debug_streak       = streak_q;

endmodule

// File: tb/tb_gesture_decision_unit.sv
// Directed bench for gesture_decision_unit: instance a uses default parameters,
// instance b uses COOLDOWN_CYCLES=3; sel picks which one the steps talk to.
module tb_gesture_decision_unit;

  localparam int N  = 4;
  localparam int AB = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          tb_valid;
  logic          sel;
  logic [N*AB-1:0] flat;

  logic       rdy_a, gv_a, done_a, pass_a, rdy_b, gv_b, done_b, pass_b;
  logic [1:0] g_a, g_b, sk_a, sk_b;
  logic [3:0] c_a, c_b;
  logic [2:0] st_a, st_b;

  logic       m_rdy, m_gv, m_done, m_pass;
  logic [1:0] m_g, m_sk;
  logic [3:0] m_c;
  logic [2:0] m_st;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gesture_decision_unit dut_a (
    .clk(clk), .rst(rst), .scores_valid(tb_valid && !sel), .scores_flat(flat),
    .scores_ready(rdy_a), .gesture(g_a), .gesture_valid(gv_a), .gesture_confidence(c_a),
    .decision_done(done_a), .decision_pass(pass_a), .debug_state(st_a), .debug_streak(sk_a)
  );

  gesture_decision_unit #(.COOLDOWN_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .scores_valid(tb_valid && sel), .scores_flat(flat),
    .scores_ready(rdy_b), .gesture(g_b), .gesture_valid(gv_b), .gesture_confidence(c_b),
    .decision_done(done_b), .decision_pass(pass_b), .debug_state(st_b), .debug_streak(sk_b)
  );

  assign m_rdy  = sel ? rdy_b  : rdy_a;
  assign m_gv   = sel ? gv_b   : gv_a;
  assign m_done = sel ? done_b : done_a;
  assign m_pass = sel ? pass_b : pass_a;
  assign m_g    = sel ? g_b    : g_a;
  assign m_sk   = sel ? sk_b   : sk_a;
  assign m_c    = sel ? c_b    : c_a;
  assign m_st   = sel ? st_b   : st_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N*AB-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [AB-1:0] ta, tb, tc, td;
    ta = a[AB-1:0];
    tb = b[AB-1:0];
    tc = c[AB-1:0];
    td = d[AB-1:0];
    return {td, tc, tb, ta};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready, offers one vector for a single accept edge, then scrambles the bus.
  task automatic start_vec(input string tag, input logic [N*AB-1:0] v);
    int w = 0;
    while (!m_rdy && w < 20) begin
      step();
      w++;
    end
    check({tag, ".ready_before"}, 32'(m_rdy), 32'd1);
    tb_valid = 1'b1;
    flat     = v;
    step();
    tb_valid = 1'b0;
    flat     = {$urandom, $urandom, $urandom};
  endtask

  // Called just after the accept edge E0; walks to E0+5 (and E0+6 unless a cooldown follows).
  task automatic finish_vec(input string tag, input bit exp_pass, input bit exp_emit,
                            input int exp_g, input int exp_c, input int exp_streak, input bit exp_cd);
    check({tag, ".state_scan"}, 32'(m_st), 32'd1);
    check({tag, ".ready_busy"}, 32'(m_rdy), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("%s.quiet%0d", tag, k), 32'({m_rdy, m_done, m_gv}), 32'd0);
    end
    check({tag, ".state_decide"}, 32'(m_st), 32'd2);
    step();
    check({tag, ".done"}, 32'(m_done), 32'd1);
    check({tag, ".pass"}, 32'(m_pass), 32'(exp_pass));
    check({tag, ".gvalid"}, 32'(m_gv), 32'(exp_emit));
    check({tag, ".streak"}, 32'(m_sk), 32'(exp_streak));
    check({tag, ".ready_after"}, 32'(m_rdy), exp_cd ? 32'd0 : 32'd1);
    check({tag, ".state_after"}, 32'(m_st), exp_cd ? 32'd3 : 32'd0);
    if (exp_emit) begin
      check({tag, ".gesture"}, 32'(m_g), 32'(exp_g));
      check({tag, ".conf"}, 32'(m_c), 32'(exp_c));
    end
    if (!exp_cd) begin
      step();
      check({tag, ".pulse_end"}, 32'({m_done, m_gv}), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel      = 1'b0;
    rst      = 1'b1;
    tb_valid = 1'b0;
    flat     = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state on both instances.
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      check($sformatf("rst%0d.ready", i), 32'(m_rdy), 32'd0);
      check($sformatf("rst%0d.state", i), 32'(m_st), 32'd0);
      check($sformatf("rst%0d.outs", i), 32'({m_gv, m_done, m_pass, m_g, m_c, m_sk}), 32'd0);
    end
    sel = 1'b0;
    rst = 1'b0;
    #1;
    check("rst.ready_release", 32'(m_rdy), 32'd1);
    step();

    // 1: same passing vector twice emits class 1 with confidence 30>>3 = 3.
    start_vec("t1a", pack4(10, 50, 20, 5));
    finish_vec("t1a", 1'b1, 1'b0, 0, 0, 1, 1'b0);
    start_vec("t1b", pack4(10, 50, 20, 5));
    finish_vec("t1b", 1'b1, 1'b1, 1, 3, 0, 1'b0);

    // 2: tied best makes the margin 0 -> fail.
    start_vec("t2", pack4(40, 40, 0, 0));
    finish_vec("t2", 1'b0, 1'b0, 0, 0, 0, 1'b0);

    // 3: all-negative vector fails the threshold; next pass only starts a streak.
    start_vec("t3a", pack4(-100, -200, -50, -300));
    finish_vec("t3a", 1'b0, 1'b0, 0, 0, 0, 1'b0);
    start_vec("t3b", pack4(0, 60, 0, 0));
    finish_vec("t3b", 1'b1, 1'b0, 0, 0, 1, 1'b0);

    // Clear the streak before the class-switch sequence.
    start_vec("clr", pack4(40, 40, 0, 0));
    finish_vec("clr", 1'b0, 1'b0, 0, 0, 0, 1'b0);

    // 4: class switch restarts the streak; emit class 0, conf 60>>3 = 7; then restart at 1.
    start_vec("t4a", pack4(0, 60, 0, 0));
    finish_vec("t4a", 1'b1, 1'b0, 0, 0, 1, 1'b0);
    start_vec("t4b", pack4(60, 0, 0, 0));
    finish_vec("t4b", 1'b1, 1'b0, 0, 0, 1, 1'b0);
    start_vec("t4c", pack4(60, 0, 0, 0));
    finish_vec("t4c", 1'b1, 1'b1, 0, 7, 0, 1'b0);
    start_vec("t4d", pack4(60, 0, 0, 0));
    finish_vec("t4d", 1'b1, 1'b0, 0, 0, 1, 1'b0);

    // 6: reset mid-SCAN of the vector that would otherwise emit.
    start_vec("t6", pack4(60, 0, 0, 0));
    step();
    step();
    check("t6.in_scan", 32'(m_st), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t6.state", 32'(m_st), 32'd0);
    check("t6.streak", 32'(m_sk), 32'd0);
    check("t6.outs", 32'({m_gv, m_done, m_pass, m_g, m_c}), 32'd0);
    check("t6.ready", 32'(m_rdy), 32'd1);
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("t6.no_pulse%0d", k), 32'({m_gv, m_done}), 32'd0);
    end
    start_vec("t6b", pack4(60, 0, 0, 0));
    finish_vec("t6b", 1'b1, 1'b0, 0, 0, 1, 1'b0);

    // 5: cooldown instance, saturated confidence, ready low 3 cycles with valid held.
    sel = 1'b1;
    #1;
    start_vec("t5a", pack4(200000, 0, 0, 0));
    finish_vec("t5a", 1'b1, 1'b0, 0, 0, 1, 1'b0);
    start_vec("t5b", pack4(200000, 0, 0, 0));
    finish_vec("t5b", 1'b1, 1'b1, 0, 15, 0, 1'b1);
    tb_valid = 1'b1;
    flat     = pack4(200000, 0, 0, 0);
    for (int k = 1; k <= 2; k++) begin
      step();
      check($sformatf("t5.cool%0d", k), 32'({m_rdy, m_st}), 32'({1'b0, 3'd3}));
    end
    step();
    check("t5.cool_exit", 32'({m_rdy, m_st}), 32'({1'b1, 3'd0}));
    step();
    tb_valid = 1'b0;
    finish_vec("t5c", 1'b1, 1'b0, 0, 0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
